// File: rtl/countdown_timer.sv
//==============================================================================
// Module      : countdown_timer
// Description : Programmable delay generator with one-shot/periodic modes,
//               pause, abort and retrigger.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_duration,
    input  logic             i_periodic,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_remaining,
    output logic             o_busy,
    output logic             o_expired,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic             r_expired;
    logic             w_last;

    assign w_last = (r_remaining == c_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_period    <= '0;
            r_mode      <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (i_abort) begin
                r_state     <= S_IDLE;
                r_remaining <= '0;
            end else if (i_load) begin
                if (i_duration != '0) begin
                    r_period    <= i_duration;
                    r_mode      <= i_periodic;
                    r_remaining <= i_duration;
                    r_state     <= S_RUNNING;
                end else begin
                    // A zero period cannot auto-reload, so it always finishes as a one-shot.
                    r_period    <= '0;
                    r_mode      <= 1'b0;
                    r_remaining <= '0;
                    r_expired   <= 1'b1;
                    r_state     <= S_DONE;
                end
            end else begin
                case (r_state)
                    S_RUNNING, S_PAUSED: begin
                        if (i_pause) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_state <= S_RUNNING;
                            if (w_last) begin
                                r_expired <= 1'b1;
                                if (r_mode) begin
                                    r_remaining <= r_period;
                                end else begin
                                    r_remaining <= '0;
                                    r_state     <= S_DONE;
                                end
                            end else begin
                                r_remaining <= r_remaining - c_ONE;
                            end
                        end
                    end
                    default: begin
                        r_remaining <= '0;
                    end
                endcase
            end
        end
    end

    assign o_remaining = r_remaining;
    assign o_expired   = r_expired;
    assign o_busy      = (r_state == S_RUNNING) || (r_state == S_PAUSED);
    assign o_done      = (r_state == S_DONE);

endmodule

`default_nettype wire
